uart_led_cmd: RTL

UART_LED_CMD -- requirements
Module: uart_led_cmd

---
 rtl/uart_led_cmd.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_led_cmd.sv
// Serial command parser driving NUM_CH PWM LED channels through a simpleuart data register.
// Commands: <chan letter><hex hi><hex lo> sets a duty, 'x' clears all duties; each command is answered with 'K' or '?'.
module uart_led_cmd #(
    parameter int NUM_CH      = 3,
    parameter int PWM_W       = 8,
    parameter int TIMEOUT_CYC = 12000000
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              reg_dat_re,
    input  logic [31:0]       reg_dat_do,
    output logic              reg_dat_we,
    output logic [31:0]       reg_dat_di,
    input  logic              reg_dat_wait,
    output logic [NUM_CH-1:0] pwm_out
);
    localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       NCH8     = 8'(NUM_CH);
    localparam logic [PWM_W-1:0] CNT_MAX  = {PWM_W{1'b1}};

    typedef enum logic [1:0] {
        POLL   = 2'd0,
        GET_HI = 2'd1,
        GET_LO = 2'd2,
        SEND   = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic               re_r, we_r;
    logic [7:0]         di_r;
    logic [TMR_W-1:0]   timer_r, timer_s;
    logic [2:0]         ch_r, ch_s;
    logic [3:0]         hi_r, hi_s;
    logic [7:0]         rsp_s;
    logic               load_s;
    logic [PWM_W-1:0]   pend_r [NUM_CH];
    logic [PWM_W-1:0]   pend_s [NUM_CH];
    logic [PWM_W-1:0]   act_r  [NUM_CH];
    logic [PWM_W-1:0]   cnt_r;
    logic [NUM_CH-1:0]  pwm_r;

    logic               accept_s;
    logic [7:0]         byte_s, off_s, v_s;
    logic               is_chan_s;
    logic [4:0]         hex_s;
    logic [PWM_W-1:0]   duty_s;

    // Returns {valid, nibble} for an ASCII hex digit; letters map through their low nibble plus nine.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [4:0] r;
        if (b >= 8'h30 && b <= 8'h39) begin
            r = {1'b1, b[3:0]};
        end else if ((b >= 8'h61 && b <= 8'h66) || (b >= 8'h41 && b <= 8'h46)) begin
            r = {1'b1, b[3:0] + 4'd9};
        end else begin
            r = 5'd0;
        end
        return r;
    endfunction

    assign accept_s  = re_r && (reg_dat_do != 32'hFFFF_FFFF);
    assign byte_s    = reg_dat_do[7:0];
    assign off_s     = byte_s - 8'h61;
    assign is_chan_s = (byte_s >= 8'h61) && (off_s < NCH8);
    assign hex_s     = hex_decode(byte_s);
    assign v_s       = {hi_r, hex_s[3:0]} >> (8 - PWM_W);
    assign duty_s    = v_s[PWM_W-1:0];

    // Next-state, response and pending-duty decode.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        ch_s    = ch_r;
        hi_s    = hi_r;
        rsp_s   = 8'h3F;
        load_s  = 1'b0;
        pend_s  = pend_r;
        case (state_r)
            POLL: begin
                if (!accept_s) begin
                    state_s = POLL;
                end else if (is_chan_s) begin
                    ch_s    = off_s[2:0];
                    timer_s = '0;
                    state_s = GET_HI;
                end else if (byte_s == 8'h78) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        pend_s[i] = '0;
                    end
                    rsp_s   = 8'h4B;
                    load_s  = 1'b1;
                    state_s = SEND;
                end else if (byte_s == 8'h0D || byte_s == 8'h0A || byte_s == 8'h20) begin
                    state_s = POLL;
                end else begin
                    load_s  = 1'b1;
                    state_s = SEND;
                end
            end
            GET_HI, GET_LO: begin
                if (accept_s) begin
                    timer_s = '0;
                    if (!hex_s[4]) begin
                        load_s  = 1'b1;
                        state_s = SEND;
                    end else if (state_r == GET_HI) begin
                        hi_s    = hex_s[3:0];
                        state_s = GET_LO;
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (ch_r == 3'(i)) begin
                                pend_s[i] = duty_s;
                            end else begin
                                pend_s[i] = pend_r[i];
                            end
                        end
                        rsp_s   = 8'h4B;
                        load_s  = 1'b1;
                        state_s = SEND;
                    end
                end else if (timer_r == TMR_LAST) begin
                    timer_s = '0;
                    state_s = POLL;
                end else begin
                    timer_s = timer_r + TMR_W'(1);
                end
            end
            SEND: begin
                if (!reg_dat_wait) begin
                    state_s = POLL;
                end else begin
                    state_s = SEND;
                end
            end
            default: state_s = POLL;
        endcase
    end

    // Parser state and register-bus strobes, registered from the next state so they track the FSM.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= POLL;
            re_r    <= 1'b0;
            we_r    <= 1'b0;
            di_r    <= 8'h00;
            timer_r <= '0;
            ch_r    <= 3'd0;
            hi_r    <= 4'd0;
        end else begin
            state_r <= state_s;
            re_r    <= (state_s != SEND);
            we_r    <= (state_s == SEND);
            di_r    <= load_s ? rsp_s : di_r;
            timer_r <= timer_s;
            ch_r    <= ch_s;
            hi_r    <= hi_s;
        end
    end

    // PWM counter; active duties reload only at the wrap so a period is never cut short.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r <= '0;
            pwm_r <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_r[i] <= '0;
                act_r[i]  <= '0;
            end
        end else begin
            cnt_r <= cnt_r + PWM_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                pend_r[i] <= pend_s[i];
                act_r[i]  <= (cnt_r == CNT_MAX) ? pend_s[i] : act_r[i];
                pwm_r[i]  <= (cnt_r < act_r[i]);
            end
        end
    end

    assign reg_dat_re = re_r;
    assign reg_dat_we = we_r;
    assign reg_dat_di = {24'd0, di_r};
    assign pwm_out    = pwm_r;

endmodule
